// File: rtl/apb_mon_pkg.sv
// Shared types for the APB protocol monitor: bus phase, error codes and the
// priority resolver used when several violations land in the same cycle.
package apb_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int ERR_W   = 3;
  localparam int NUM_ERR = 6;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE            = 3'd0,
    ERR_ENABLE_NO_SETUP = 3'd1,
    ERR_SETUP_NO_ACCESS = 3'd2,
    ERR_CTRL_CHANGE     = 3'd3,
    ERR_TIMEOUT         = 3'd4,
    ERR_ILLEGAL_DIR     = 3'd5,
    ERR_OOR             = 3'd6
  } err_code_t;

  // hits[i] set means code i+1 fired; the lowest code wins.
  function automatic err_code_t first_err(input logic [NUM_ERR-1:0] hits);
    first_err = ERR_NONE;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (hits[i]) first_err = err_code_t'(ERR_W'(i + 1));
    end
  endfunction

endpackage

// File: rtl/apb_mon_sat_cnt.sv
// Saturating event counter: holds at all-ones, clr beats inc in the same cycle.
module apb_mon_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB slave-side protocol monitor: tracks transfer phases, reports
// protocol/direction/range violations and wait-state timeouts, counts events.
module apb_protocol_monitor
  import apb_mon_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] WR_MASK    = 8'b0101_0110,
  parameter logic [NUM_REGS-1:0] RD_MASK    = 8'b0010_1000,
  parameter int                  MAX_WAIT   = 16,
  parameter int                  CNT_WIDTH  = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pready,
  input  logic                  clr,
  output logic                  err_valid,
  output logic [2:0]            err_code,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [5:0]            err_sticky,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [1:0]            state_dbg
);

  localparam int                  WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0]   WAIT_FULL  = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_WIDTH:0] NUM_REGS_X = (ADDR_WIDTH + 1)'(NUM_REGS);

  apb_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0]  lat_addr;
  logic                   lat_write;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [NUM_ERR-1:0]     hits;
  logic                   latch_en, wait_inc, xfer_done, in_access;
  logic                   oor, dir_ok;
  logic [NUM_REGS-1:0]    wr_bits, rd_bits;

  assign oor       = {1'b0, paddr} >= NUM_REGS_X;
  assign wr_bits   = WR_MASK >> paddr;
  assign rd_bits   = RD_MASK >> paddr;
  assign dir_ok    = pwrite ? wr_bits[0] : rd_bits[0];
  assign state_dbg = state;

  // SETUP means the previous cycle was the setup phase, so the current cycle
  // must be the first access cycle; ACCESS means we are in wait states.
  always_comb begin
    state_nxt = state;
    hits      = '0;
    latch_en  = 1'b0;
    wait_inc  = 1'b0;
    xfer_done = 1'b0;
    in_access = 1'b0;
    case (state)
      IDLE: begin
        if (penable) begin
          hits[0] = 1'b1;
        end else if (pselx) begin
          state_nxt = SETUP;
          latch_en  = 1'b1;
          if (oor)          hits[5] = 1'b1;
          else if (!dir_ok) hits[4] = 1'b1;
        end
      end
      SETUP: begin
        if (pselx && penable) begin
          in_access = 1'b1;
        end else begin
          hits[1]   = 1'b1;
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (pselx) begin
          in_access = 1'b1;
        end else begin
          hits[2]   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (in_access) begin
      if ((paddr != lat_addr) || (pwrite != lat_write)) hits[2] = 1'b1;
      if (pready) begin
        xfer_done = 1'b1;
        state_nxt = IDLE;
      end else begin
        state_nxt = ACCESS;
        wait_inc  = 1'b1;
        // Fires only on the step into saturation, hence once per transfer.
        if (wait_cnt == WAIT_LAST) hits[3] = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (latch_en) begin
        lat_addr  <= paddr;
        lat_write <= pwrite;
        wait_cnt  <= '0;
      end else if (wait_inc && (wait_cnt != WAIT_FULL)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // err_valid is a one-cycle pulse with no ready/backpressure; err_code and
  // err_addr stay valid from that pulse until the next one.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      err_addr   <= '0;
      err_sticky <= '0;
    end else begin
      err_valid <= |hits;
      if (|hits) begin
        err_code <= first_err(hits);
        err_addr <= paddr;
      end
      err_sticky <= clr ? '0 : (err_sticky | hits);
    end
  end

  apb_mon_sat_cnt #(.W(CNT_WIDTH)) u_xfer_cnt (
    .clk (pclk),
    .rst (preset),
    .inc (xfer_done),
    .clr (clr),
    .cnt (xfer_cnt)
  );

  apb_mon_sat_cnt #(.W(CNT_WIDTH)) u_err_cnt (
    .clk (pclk),
    .rst (preset),
    .inc (|hits),
    .clr (clr),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Bench for apb_protocol_monitor: directed vector table, hand-written corner
// sequences, then randomized transactions scored against a transaction model.
module tb_apb_protocol_monitor;

  localparam int          AW  = 8;
  localparam int          NR  = 8;
  localparam int          MW  = 4;
  localparam int          CW  = 4;
  localparam logic [7:0]  WRM = 8'b0101_0110;
  localparam logic [7:0]  RDM = 8'b0010_1000;
  localparam int          CNT_MAX = 15;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          pselx = 1'b0, penable = 1'b0, pwrite = 1'b0, pready = 1'b0, clr = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic          err_valid;
  logic [2:0]    err_code;
  logic [AW-1:0] err_addr;
  logic [5:0]    err_sticky;
  logic [CW-1:0] xfer_cnt, err_cnt;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  bit   sb_on = 1'b0;
  int   m_xfer = 0;
  int   m_err  = 0;
  logic [5:0] m_sticky = '0;

  apb_protocol_monitor #(
    .ADDR_WIDTH(AW), .NUM_REGS(NR), .WR_MASK(WRM), .RD_MASK(RDM),
    .MAX_WAIT(MW), .CNT_WIDTH(CW)
  ) dut (
    .pclk(pclk), .preset(preset), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pready(pready), .clr(clr),
    .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr),
    .err_sticky(err_sticky), .xfer_cnt(xfer_cnt), .err_cnt(err_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 pclk = ~pclk;

  task automatic release_reset();
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
  endtask

  // ---------------- driver / checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic en, input logic wr,
                       input logic [AW-1:0] a, input logic rdy, input logic c);
    pselx = sel; penable = en; pwrite = wr; paddr = a; pready = rdy; clr = c;
    @(posedge pclk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [2:0] ec,
                            input logic [AW-1:0] ea, input int xc, input int ecn,
                            input logic [5:0] st);
    check({tag, ".err_valid"},  32'(err_valid),  32'(ev));
    check({tag, ".err_code"},   32'(err_code),   32'(ec));
    check({tag, ".err_addr"},   32'(err_addr),   32'(ea));
    check({tag, ".xfer_cnt"},   32'(xfer_cnt),   32'(xc));
    check({tag, ".err_cnt"},    32'(err_cnt),    32'(ecn));
    check({tag, ".err_sticky"}, 32'(err_sticky), 32'(st));
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_cycle(input logic [5:0] bits, input logic [AW-1:0] a);
    logic [2:0] code;
    if (bits != '0) begin
      code = 3'd0;
      for (int i = 5; i >= 0; i--) if (bits[i]) code = 3'(i + 1);
      exp_q.push_back({code, a});
      m_err++;
      m_sticky = m_sticky | bits;
    end
  endtask

  logic [10:0] sb_e;
  always @(negedge pclk) begin
    if (sb_on && err_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got code %0d addr 0x%0h, expected no error", err_code, err_addr);
      end else begin
        sb_e = exp_q.pop_front();
        if ({err_code, err_addr} !== sb_e) begin
          errors++;
          $display("FAIL sb_error: got code %0d addr 0x%0h, expected code %0d addr 0x%0h",
                   err_code, err_addr, sb_e[10:8], sb_e[7:0]);
        end
      end
    end
  end

  function automatic logic [5:0] setup_bits(input logic wr, input logic [AW-1:0] a);
    setup_bits = '0;
    if (a >= AW'(NR))                              setup_bits[5] = 1'b1;
    else if (!(wr ? WRM[a[2:0]] : RDM[a[2:0]]))    setup_bits[4] = 1'b1;
  endfunction

  // One random transaction, optionally with a single injected protocol fault.
  task automatic rand_xfer();
    int            kind  = $urandom_range(0, 5);
    logic [AW-1:0] a     = AW'($urandom_range(0, 11));
    logic          wr    = 1'($urandom_range(0, 1));
    int            waits = $urandom_range(0, 6);
    logic          flip_wr = 1'($urandom_range(0, 1));
    int            chg, k;
    logic [5:0]    bits;
    logic [AW-1:0] ai;
    logic          wi;
    if (kind == 2) begin
      drive(1'($urandom_range(0, 1)), 1'b1, wr, a, 1'($urandom_range(0, 1)), 1'b0);
      expect_cycle(6'b000001, a);
    end else begin
      drive(1'b1, 1'b0, wr, a, 1'b0, 1'b0);
      expect_cycle(setup_bits(wr, a), a);
      if (kind == 1) begin
        drive(1'b0, 1'($urandom_range(0, 1)), wr, a, 1'b0, 1'b0);
        expect_cycle(6'b000010, a);
      end else if (kind == 4) begin
        if (waits == 0) waits = 1;
        k = $urandom_range(1, waits);
        for (int i = 0; i < k; i++) begin
          drive(1'b1, 1'b1, wr, a, 1'b0, 1'b0);
          expect_cycle((i + 1 == MW) ? 6'b001000 : 6'b000000, a);
        end
        drive(1'b0, 1'($urandom_range(0, 1)), wr, a, 1'b0, 1'b0);
        expect_cycle(6'b000100, a);
      end else begin
        chg = (kind == 3) ? $urandom_range(0, waits) : -1;
        for (int i = 0; i <= waits; i++) begin
          bits = '0; ai = a; wi = wr;
          if (i == chg) begin
            if (flip_wr) wi = ~wr;
            else         ai = a ^ 8'h01;
            bits[2] = 1'b1;
          end
          if (i < waits && i + 1 == MW) bits[3] = 1'b1;
          drive(1'b1, 1'b1, wi, ai, 1'(i == waits), 1'b0);
          expect_cycle(bits, ai);
        end
        m_xfer++;
      end
    end
    repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          sel, en, wr;
    logic [AW-1:0] a;
    logic          rdy, c;
    logic          ev;
    logic [2:0]    ec;
    logic [AW-1:0] ea;
    logic [3:0]    xc, ecn;
    logic [5:0]    st;
  } vec_t;

  vec_t vt[26];

  initial begin
    // write reg 2, zero wait
    vt[0]  = '{1'b1,1'b0,1'b1,8'd2,1'b0,1'b0, 1'b0,3'd0,8'd0,4'd0,4'd0,6'b000000};
    vt[1]  = '{1'b1,1'b1,1'b1,8'd2,1'b1,1'b0, 1'b0,3'd0,8'd0,4'd1,4'd0,6'b000000};
    vt[2]  = '{1'b0,1'b0,1'b0,8'd0,1'b0,1'b0, 1'b0,3'd0,8'd0,4'd1,4'd0,6'b000000};
    // read reg 3 with three wait states
    vt[3]  = '{1'b1,1'b0,1'b0,8'd3,1'b0,1'b0, 1'b0,3'd0,8'd0,4'd1,4'd0,6'b000000};
    vt[4]  = '{1'b1,1'b1,1'b0,8'd3,1'b0,1'b0, 1'b0,3'd0,8'd0,4'd1,4'd0,6'b000000};
    vt[5]  = '{1'b1,1'b1,1'b0,8'd3,1'b0,1'b0, 1'b0,3'd0,8'd0,4'd1,4'd0,6'b000000};
    vt[6]  = '{1'b1,1'b1,1'b0,8'd3,1'b0,1'b0, 1'b0,3'd0,8'd0,4'd1,4'd0,6'b000000};
    vt[7]  = '{1'b1,1'b1,1'b0,8'd3,1'b1,1'b0, 1'b0,3'd0,8'd0,4'd2,4'd0,6'b000000};
    vt[8]  = '{1'b0,1'b0,1'b0,8'd0,1'b0,1'b0, 1'b0,3'd0,8'd0,4'd2,4'd0,6'b000000};
    // write to read-only reg 3
    vt[9]  = '{1'b1,1'b0,1'b1,8'd3,1'b0,1'b0, 1'b1,3'd5,8'd3,4'd2,4'd1,6'b010000};
    vt[10] = '{1'b1,1'b1,1'b1,8'd3,1'b1,1'b0, 1'b0,3'd5,8'd3,4'd3,4'd1,6'b010000};
    vt[11] = '{1'b0,1'b0,1'b0,8'd0,1'b0,1'b0, 1'b0,3'd5,8'd3,4'd3,4'd1,6'b010000};
    // penable with no setup
    vt[12] = '{1'b1,1'b1,1'b0,8'd5,1'b0,1'b0, 1'b1,3'd1,8'd5,4'd3,4'd2,6'b010001};
    vt[13] = '{1'b0,1'b0,1'b0,8'd0,1'b0,1'b0, 1'b0,3'd1,8'd5,4'd3,4'd2,6'b010001};
    // paddr changes 4 -> 6 mid-access
    vt[14] = '{1'b1,1'b0,1'b1,8'd4,1'b0,1'b0, 1'b0,3'd1,8'd5,4'd3,4'd2,6'b010001};
    vt[15] = '{1'b1,1'b1,1'b1,8'd4,1'b0,1'b0, 1'b0,3'd1,8'd5,4'd3,4'd2,6'b010001};
    vt[16] = '{1'b1,1'b1,1'b1,8'd6,1'b0,1'b0, 1'b1,3'd3,8'd6,4'd3,4'd3,6'b010101};
    vt[17] = '{1'b1,1'b1,1'b1,8'd4,1'b1,1'b0, 1'b0,3'd3,8'd6,4'd4,4'd3,6'b010101};
    vt[18] = '{1'b0,1'b0,1'b0,8'd0,1'b0,1'b0, 1'b0,3'd3,8'd6,4'd4,4'd3,6'b010101};
    // out-of-range read at addr 9 (direction check suppressed)
    vt[19] = '{1'b1,1'b0,1'b0,8'd9,1'b0,1'b0, 1'b1,3'd6,8'd9,4'd4,4'd4,6'b110101};
    vt[20] = '{1'b1,1'b1,1'b0,8'd9,1'b1,1'b0, 1'b0,3'd6,8'd9,4'd5,4'd4,6'b110101};
    vt[21] = '{1'b0,1'b0,1'b0,8'd0,1'b0,1'b0, 1'b0,3'd6,8'd9,4'd5,4'd4,6'b110101};
    // setup not followed by access
    vt[22] = '{1'b1,1'b0,1'b0,8'd5,1'b0,1'b0, 1'b0,3'd6,8'd9,4'd5,4'd4,6'b110101};
    vt[23] = '{1'b0,1'b0,1'b0,8'd5,1'b0,1'b0, 1'b1,3'd2,8'd5,4'd5,4'd5,6'b110111};
    // clr in the same cycle as an error
    vt[24] = '{1'b1,1'b1,1'b0,8'd7,1'b0,1'b1, 1'b1,3'd1,8'd7,4'd0,4'd0,6'b000000};
    vt[25] = '{1'b0,1'b0,1'b0,8'd0,1'b0,1'b0, 1'b0,3'd1,8'd7,4'd0,4'd0,6'b000000};
  end

  // ---------------- main sequence ----------------
  initial begin
    @(negedge pclk);
    check_outs("reset", 1'b0, 3'd0, 8'd0, 0, 0, 6'b000000);
    release_reset();

    for (int r = 0; r < 26; r++) begin
      drive(vt[r].sel, vt[r].en, vt[r].wr, vt[r].a, vt[r].rdy, vt[r].c);
      check_outs($sformatf("vec%0d", r), vt[r].ev, vt[r].ec, vt[r].ea,
                 int'(vt[r].xc), int'(vt[r].ecn), vt[r].st);
    end

    // Timeout: pready low for 10 cycles gives one pulse after the 4th wait.
    drive(1'b1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
      check($sformatf("timeout_pulse%0d", i), 32'(err_valid), 32'(i == MW - 1));
      if (i == MW - 1) check("timeout_code", 32'(err_code), 32'd4);
    end
    drive(1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 1'b0);
    check_outs("timeout_done", 1'b0, 3'd4, 8'd2, 1, 1, 6'b001000);

    // Control change and timeout in the same cycle: code 3 wins, one count.
    drive(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);
    for (int i = 0; i < MW - 1; i++) drive(1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0);
    check_outs("prio", 1'b1, 3'd3, 8'd5, 1, 2, 6'b001100);
    drive(1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0);
    check("prio_no_retimeout", 32'(err_valid), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
    check_outs("prio_done", 1'b0, 3'd3, 8'd5, 2, 2, 6'b001100);

    // Async reset in the middle of a waiting access.
    drive(1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
    pselx = 1'b0; penable = 1'b0; pready = 1'b0;
    #2 preset = 1'b1;
    #1 check_outs("async_reset", 1'b0, 3'd0, 8'd0, 0, 0, 6'b000000);
    release_reset();
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check_outs("after_reset", 1'b0, 3'd0, 8'd0, 0, 0, 6'b000000);

    // Randomized transactions against the transaction-level model.
    sb_on = 1'b1;
    for (int t = 0; t < 60; t++) rand_xfer();
    repeat (2) drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    sb_on = 1'b0;
    check("rand_queue_left", 32'(exp_q.size()), 32'd0);
    check("rand_xfer_cnt", 32'(xfer_cnt), 32'((m_xfer > CNT_MAX) ? CNT_MAX : m_xfer));
    check("rand_err_cnt", 32'(err_cnt), 32'((m_err > CNT_MAX) ? CNT_MAX : m_err));
    check("rand_sticky", 32'(err_sticky), 32'(m_sticky));

    // clr wipes counters and sticky flags but keeps the last error code.
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    check("clr_xfer", 32'(xfer_cnt), 32'd0);
    check("clr_err", 32'(err_cnt), 32'd0);
    check("clr_sticky", 32'(err_sticky), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
